// File: rtl/autobaud_ctrl.sv
// autobaud_ctrl: UART auto-baud controller (ser_in/start/abort in; busy/lock/err/divisor/baud_tick/relock_evt out); optional relock via AUTOBAUD_RELOCK_EN
module autobaud_ctrl #(
  parameter int CNT_W     = 18,
  parameter int NUM_EDGES = 4,
  parameter int MIN_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] divisor,
  output logic             baud_tick,
  output logic             relock_evt
);
  localparam int N_W = $clog2(NUM_EDGES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED, ERROR} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, fe, done, relock;
  logic [CNT_W-1:0] cnt, ivl, min_r, min_nx, d, tick_cnt;
  logic [N_W-1:0] n;
  assign fe = ~s2 & s3;
  assign ivl = cnt == '1 ? cnt : cnt + 1'b1;
  assign min_nx = ivl < min_r ? ivl : min_r;
  assign d = min_nx >> 4;
  assign done = state == MEASURE && fe && n == N_W'(NUM_EDGES - 1);
`ifdef AUTOBAUD_RELOCK_EN
  assign relock = state == LOCKED && fe && {3'b000, ivl} < {divisor, 3'b000};
`else
  assign relock = 1'b0;
`endif
  assign busy = state == WAIT_EDGE || state == MEASURE;
  assign lock = state == LOCKED;
  assign err = state == ERROR;
  assign baud_tick = state == LOCKED && tick_cnt == '0;
  assign relock_evt = relock;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? WAIT_EDGE : IDLE;
      WAIT_EDGE: state_nx = fe ? MEASURE : WAIT_EDGE;
      MEASURE:   state_nx = done ? (d < CNT_W'(MIN_DIV) ? ERROR : LOCKED) : (cnt == '1 && !fe) ? ERROR : MEASURE;
      LOCKED:    state_nx = start ? WAIT_EDGE : relock ? MEASURE : LOCKED;
      ERROR:     state_nx = start ? WAIT_EDGE : ERROR;
      default:   state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {s1, s2, s3} <= 3'b111;
      cnt <= '0;
      min_r <= '1;
      n <= '0;
      divisor <= '0;
      tick_cnt <= '0;
    end else begin
      state <= state_nx;
      {s1, s2, s3} <= {ser_in, s1, s2};
      cnt <= fe ? '0 : ivl;
      if (state_nx == WAIT_EDGE || relock) begin
        min_r <= '1;
        n <= '0;
      end else if (state == MEASURE && fe) begin
        min_r <= min_nx;
        n <= n + 1'b1;
      end
      if (done && state_nx == LOCKED) divisor <= d;
      tick_cnt <= state != LOCKED ? d - 1'b1 : tick_cnt == '0 ? divisor - 1'b1 : tick_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_autobaud_ctrl.sv
// tb_autobaud_ctrl: directed bench for autobaud_ctrl with a cycle-time behavioural model checked every cycle
module tb_autobaud_ctrl;
  localparam int W = 13, NE = 4, MINDIV = 2, MAXV = (1 << W) - 1;
`ifdef AUTOBAUD_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ser_in = 1'b1, start = 1'b0, abort = 1'b0;
  logic busy, lock, err, baud_tick, relock_evt;
  logic [W-1:0] divisor;
  autobaud_ctrl #(.CNT_W(W), .NUM_EDGES(NE), .MIN_DIV(MINDIV)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .start(start), .abort(abort),
    .busy(busy), .lock(lock), .err(err), .divisor(divisor),
    .baud_tick(baud_tick), .relock_evt(relock_evt)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int now = 0, mode = 0, last_fe = 0, mmin = MAXV, mn = 0, mdiv = 0, lock_t = 0, pend = 0, k = 0;
  bit q1 = 1, q2 = 1, q3 = 1, saw_rel = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, now, a, e);
    end
  endtask
  task automatic cyc();
    bit fe;
    int ivl, nm;
    @(posedge clk);
    if (rst) begin
      mode = 0; mdiv = 0; last_fe = now; q1 = 1; q2 = 1; q3 = 1;
    end else begin
      fe = !q2 && q3;
      ivl = (now - last_fe > MAXV) ? MAXV : now - last_fe;
      nm = mode;
      case (mode)
        0, 4: if (start) begin nm = 1; mmin = MAXV; mn = 0; end
        1: if (fe) nm = 2;
        2: if (fe) begin
             mmin = ivl < mmin ? ivl : mmin;
             mn++;
             if (mn == NE) begin
               if ((mmin >> 4) < MINDIV) nm = 4;
               else begin nm = 3; pend = mmin >> 4; end
             end
           end else if (now - last_fe >= (1 << W)) nm = 4;
        3: if (start) begin nm = 1; mmin = MAXV; mn = 0; end
           else if (RELOCK && fe && ivl < mdiv * 8) begin nm = 2; mmin = MAXV; mn = 0; end
        default: nm = 0;
      endcase
      if (abort) nm = 0;
      if (nm == 3 && mode != 3) begin mdiv = pend; lock_t = now; end
      mode = nm;
      if (fe) last_fe = now;
      q3 = q2; q2 = q1; q1 = ser_in;
    end
    now++;
    #1;
    fe = !q2 && q3;
    ivl = (now - last_fe > MAXV) ? MAXV : now - last_fe;
    if (relock_evt === 1'b1) saw_rel = 1;
    chk("busy", busy, mode == 1 || mode == 2);
    chk("lock", lock, mode == 3);
    chk("err", err, mode == 4);
    chk("divisor", divisor, mdiv);
    chk("baud_tick", baud_tick, mode == 3 && ((now - lock_t) % (mdiv == 0 ? 1 : mdiv)) == 0);
    chk("relock_evt", relock_evt, RELOCK && mode == 3 && fe && ivl < mdiv * 8);
  endtask
  task automatic pulse_gap(input int gap);
    ser_in = 1'b0;
    repeat (gap / 2) cyc();
    ser_in = 1'b1;
    repeat (gap - gap / 2) cyc();
  endtask
  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask
  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_div", divisor, 0);
    chk("rst_busy", busy, 0);
    go();
    chk("t1_busy", busy, 1);
    repeat (4) pulse_gap(1600);
    ser_in = 1'b0;
    k = 0;
    while (baud_tick !== 1'b1 && k < 300) begin
      cyc();
      k++;
      if (k == 4) ser_in = 1'b1;
    end
    chk("t1_first_tick", k, 102);
    chk("t1_div", divisor, 100);
    chk("t1_lock", lock, 1);
    k = 0;
    do begin cyc(); k++; end while (baud_tick !== 1'b1 && k < 300);
    chk("t1_period", k, 100);
    go();
    pulse_gap(3200); pulse_gap(1600); pulse_gap(4800); pulse_gap(1600);
    ser_in = 1'b0;
    cyc(); cyc();
    chk("t2_lock_early", lock, 0);
    cyc();
    chk("t2_lock", lock, 1);
    chk("t2_div", divisor, 100);
    ser_in = 1'b1;
    repeat (5) cyc();
    go();
    repeat (4) pulse_gap(20);
    ser_in = 1'b0;
    repeat (3) cyc();
    chk("t3_err", err, 1);
    chk("t3_lock", lock, 0);
    ser_in = 1'b1;
    cyc();
    go();
    chk("t3_err_clr", err, 0);
    chk("t3_busy", busy, 1);
    repeat (5) cyc();
    ser_in = 1'b0;
    k = 0;
    while (err !== 1'b1 && k < 9000) begin
      cyc();
      k++;
      if (k == 4) ser_in = 1'b1;
    end
    chk("t4_timeout_at", k, 8195);
    go();
    pulse_gap(8192);
    ser_in = 1'b0;
    repeat (8) cyc();
    chk("t4_sat_edge_err", err, 0);
    chk("t4_sat_edge_busy", busy, 1);
    ser_in = 1'b1;
    pulse_gap(1600);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_div", divisor, 100);
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("t5_both_busy", busy, 0);
    cyc();
    chk("t5_both_lock", lock, 0);
    go();
    repeat (4) pulse_gap(1600);
    pulse_gap(700);
    saw_rel = 0;
    repeat (4) pulse_gap(800);
    ser_in = 1'b0;
    repeat (4) cyc();
    ser_in = 1'b1;
    repeat (4) cyc();
    chk("t6_relock_seen", saw_rel, RELOCK);
    chk("t6_div", divisor, RELOCK ? 50 : 100);
    chk("t6_lock", lock, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
